// File: rtl/inert_pkg.sv
// Shared types and IMU command constants for the inertial interface.
// The config writes and read addresses match the IMU register map.
package inert_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        CFG,
        WAIT_INT,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH,
        DONE
    } inert_state_t;

    localparam logic [15:0] CFG_INT   = 16'h0D02;
    localparam logic [15:0] CFG_ACCEL = 16'h1053;
    localparam logic [15:0] CFG_GYRO  = 16'h1150;
    localparam logic [15:0] CFG_ROUND = 16'h1460;

    localparam logic [7:0] PTCH_L = 8'hA2;
    localparam logic [7:0] PTCH_H = 8'hA3;
    localparam logic [7:0] AZ_L   = 8'hAC;
    localparam logic [7:0] AZ_H   = 8'hAD;

    // Configuration writes go out in index order 0..3.
    function automatic logic [15:0] cfg_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CFG_INT;
            2'd1:    return CFG_ACCEL;
            2'd2:    return CFG_GYRO;
            default: return CFG_ROUND;
        endcase
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [7:0] addr);
        return {addr, 8'h00};
    endfunction

endpackage

// File: rtl/spi_monarch.sv
// 16-bit SPI master: mode 3 (SCLK idles high), MOSI changes on SCLK fall,
// MISO sampled on SCLK rise. done pulses with the SS_n rise.
module spi_monarch #(
    parameter int SCLK_DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    // Divider starts at half scale so SCLK holds high for half a period after SS_n falls.
    localparam logic [SCLK_DIV_W-1:0] DIV_START = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL  = '1;
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE  = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

    logic                  busy;
    logic [SCLK_DIV_W-1:0] div;
    logic [4:0]            rise_cnt;
    logic [15:0]           tx_shft;
    logic [15:0]           rx_shft;

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst) begin
            busy     <= 1'b0;
            div      <= '0;
            rise_cnt <= '0;
            tx_shft  <= '0;
            rx_shft  <= '0;
            SS_n     <= 1'b1;
            SCLK     <= 1'b1;
            MOSI     <= 1'b0;
        end else if (!busy) begin
            if (wrt) begin
                busy     <= 1'b1;
                SS_n     <= 1'b0;
                div      <= DIV_START;
                rise_cnt <= '0;
                tx_shft  <= cmd;
            end
        end else begin
            div <= div + 1'b1;
            // The fall slot after the 16th rise becomes the back porch end instead.
            if (div == DIV_FALL) begin
                if (rise_cnt == 5'd16) begin
                    busy <= 1'b0;
                    SS_n <= 1'b1;
                    done <= 1'b1;
                end else begin
                    SCLK    <= 1'b0;
                    MOSI    <= tx_shft[15];
                    tx_shft <= {tx_shft[14:0], 1'b0};
                end
            end
            if (div == DIV_RISE) begin
                SCLK     <= 1'b1;
                rx_shft  <= {rx_shft[14:0], MISO};
                rise_cnt <= rise_cnt + 5'd1;
            end
        end
    end

    assign rd_data = rx_shft[7:0];

endmodule

// File: rtl/inertial_interface.sv
// IMU front end: power-up wait, four config writes, then a four-byte read
// burst per data-ready interrupt, delivering ptch_rt/AZ with a vld strobe.
module inertial_interface
    import inert_pkg::*;
#(
    parameter int INIT_WAIT_W = 16,
    parameter int SCLK_DIV_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    inert_state_t           state;
    logic [INIT_WAIT_W-1:0] wait_cnt;
    logic [1:0]             cfg_idx;
    logic                   wrt;
    logic                   done;
    logic [15:0]            cmd;
    logic [7:0]             rd_data;
    logic                   int_meta;
    logic                   int_sync;
    logic [7:0]             pitch_l, pitch_h, az_l, az_h;

    spi_monarch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    // INT comes from the IMU clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_meta <= 1'b0;
            int_sync <= 1'b0;
        end else begin
            int_meta <= INT;
            int_sync <= int_meta;
        end
    end

    always_ff @(posedge clk) begin
        wrt <= 1'b0;
        vld <= 1'b0;
        if (rst) begin
            state    <= INIT_WAIT;
            wait_cnt <= '0;
            cfg_idx  <= '0;
            cmd      <= '0;
            pitch_l  <= '0;
            pitch_h  <= '0;
            az_l     <= '0;
            az_h     <= '0;
            ptch_rt  <= '0;
            AZ       <= '0;
        end else begin
            case (state)
                INIT_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (&wait_cnt) begin
                        state   <= CFG;
                        cfg_idx <= 2'd0;
                        cmd     <= cfg_cmd(2'd0);
                        wrt     <= 1'b1;
                    end
                end
                CFG: begin
                    if (done) begin
                        if (cfg_idx == 2'd3) begin
                            state <= WAIT_INT;
                        end else begin
                            cfg_idx <= cfg_idx + 2'd1;
                            cmd     <= cfg_cmd(cfg_idx + 2'd1);
                            wrt     <= 1'b1;
                        end
                    end
                end
                WAIT_INT: begin
                    if (int_sync) begin
                        cmd   <= rd_cmd(PTCH_L);
                        wrt   <= 1'b1;
                        state <= RD_PL;
                    end
                end
                RD_PL: begin
                    if (done) begin
                        pitch_l <= rd_data;
                        cmd     <= rd_cmd(PTCH_H);
                        wrt     <= 1'b1;
                        state   <= RD_PH;
                    end
                end
                RD_PH: begin
                    if (done) begin
                        pitch_h <= rd_data;
                        cmd     <= rd_cmd(AZ_L);
                        wrt     <= 1'b1;
                        state   <= RD_AL;
                    end
                end
                RD_AL: begin
                    if (done) begin
                        az_l  <= rd_data;
                        cmd   <= rd_cmd(AZ_H);
                        wrt   <= 1'b1;
                        state <= RD_AH;
                    end
                end
                RD_AH: begin
                    if (done) begin
                        az_h  <= rd_data;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ptch_rt <= {pitch_h, pitch_l};
                    AZ      <= {az_h, az_l};
                    vld     <= 1'b1;
                    state   <= WAIT_INT;
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end

endmodule
